// File: rtl/memory_stage_pkg.sv
// Shared widths and state type for the memory stage; the widths mirror the
// RW/REGNO defines used across the core.
package memory_stage_pkg;

    localparam int MS_RW    = 16;
    localparam int MS_REGNO = 8;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } ms_state_e;

endpackage

// File: rtl/memory_stage.sv
// Memory pipeline stage: forwards ALU results to writeback, or runs one
// req/ack data-bus transaction per memory instruction and writes back loads.
//
// Handshake: an instruction transfers on any rising edge where i_submit=1 and
// the stage is idle. o_ready reports idle, but is pulled low combinationally in
// the same cycle a memory instruction is presented, so execute stalls its next
// instruction until the bus transaction has finished. The bus request is held
// high with stable address/data/strobe until i_mem_ack; acks seen while no
// request is outstanding are ignored.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int RW    = MS_RW,
    parameter int REGNO = MS_REGNO
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_ready,
    input  logic             i_submit,
    input  logic [RW-1:0]    i_data,
    input  logic [RW-1:0]    i_addr,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    input  logic             i_mem_ack,
    input  logic [RW-1:0]    i_mem_data,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_dbg_state
);

    ms_state_e        state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [RW-1:0]    mem_addr_q, mem_addr_d;
    logic [RW-1:0]    mem_data_q, mem_data_d;
    logic [REGNO-1:0] mask_q, mask_d;
    logic [REGNO-1:0] reg_ie_q, reg_ie_d;
    logic [RW-1:0]    reg_data_q, reg_data_d;
    logic             ack_valid;

    assign ack_valid = i_mem_ack & mem_req_q;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mask_d     = mask_q;
        reg_data_d = reg_data_q;
        reg_ie_d   = '0;
        o_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_ready = ~(i_submit & i_mem_access);
                if (i_submit) begin
                    if (i_mem_access) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = i_mem_we;
                        mem_addr_d = i_addr;
                        mem_data_d = i_data;
                        mask_d     = i_reg_ie;
                        state_d    = ST_MEM_WAIT;
                    end else begin
                        reg_ie_d   = i_reg_ie;
                        reg_data_d = i_data;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (ack_valid) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                    // Stores complete silently; loads return data to the masked register.
                    if (!mem_we_q) begin
                        reg_ie_d   = mask_q;
                        reg_data_d = i_mem_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mask_q     <= '0;
            reg_ie_q   <= '0;
            reg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mask_q     <= mask_d;
            reg_ie_q   <= reg_ie_d;
            reg_data_q <= reg_data_d;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_reg_ie    = reg_ie_q;
    assign o_reg_data  = reg_data_q;
    assign o_dbg_state = state_q;

    // Execute must not present a new instruction while a bus transaction is open.
    property p_no_submit_while_busy;
        @(posedge i_clk) disable iff (i_rst) (state_q == ST_MEM_WAIT) |-> !i_submit;
    endproperty
    a_no_submit_while_busy: assert property (p_no_submit_while_busy);

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed and random instruction streams,
// a randomly delayed bus slave, and an in-order writeback reference model.
module tb_memory_stage;

  localparam int RW    = 16;
  localparam int REGNO = 8;

  typedef struct {
    logic             mem;
    logic             we;
    logic [RW-1:0]    addr;
    logic [RW-1:0]    data;
    logic [REGNO-1:0] mask;
    int               wait_cycles;
  } instr_t;

  typedef struct {
    logic [REGNO-1:0] mask;
    logic [RW-1:0]    data;
    logic             is_mem;
    int               cyc;
  } wb_t;

  typedef struct {
    logic          we;
    logic [RW-1:0] addr;
    logic [RW-1:0] data;
  } bus_t;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic             o_ready;
  logic             i_submit = 1'b0;
  logic [RW-1:0]    i_data = '0;
  logic [RW-1:0]    i_addr = '0;
  logic [REGNO-1:0] i_reg_ie = '0;
  logic             i_mem_access = 1'b0;
  logic             i_mem_we = 1'b0;
  logic             o_mem_req;
  logic             o_mem_we;
  logic [RW-1:0]    o_mem_addr;
  logic [RW-1:0]    o_mem_data;
  logic             i_mem_ack = 1'b0;
  logic [RW-1:0]    i_mem_data = '0;
  logic [REGNO-1:0] o_reg_ie;
  logic [RW-1:0]    o_reg_data;
  logic             o_dbg_state;

  memory_stage #(.RW(RW), .REGNO(REGNO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready), .i_submit(i_submit),
    .i_data(i_data), .i_addr(i_addr), .i_reg_ie(i_reg_ie),
    .i_mem_access(i_mem_access), .i_mem_we(i_mem_we),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .o_reg_ie(o_reg_ie), .o_reg_data(o_reg_data), .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // scoreboard state
  wb_t    exp_q[$];
  bus_t   bus_q[$];
  instr_t instr_q[$];
  logic [RW-1:0] ref_mem[logic [RW-1:0]];
  logic [RW-1:0] slave_mem[logic [RW-1:0]];

  logic pending = 1'b0;
  logic ack_real = 1'b0;
  int   wait_cnt = 0;
  int   pend_cyc = 0;
  int   ack_cyc = 0;
  logic monitor_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [RW-1:0] init_word(input logic [RW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [RW-1:0] ref_read(input logic [RW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [RW-1:0] slave_read(input logic [RW-1:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  // monitor: writebacks and bus activity, sampled 1 time unit after the edge
  logic          prev_req = 1'b0;
  logic          cap_we;
  logic [RW-1:0] cap_addr, cap_data;

  always @(posedge i_clk) begin
    cyc++;
    #1;
    if (monitor_on) begin
      if (o_reg_ie != '0) begin
        if (exp_q.size() == 0) begin
          fail_now("wb_unexpected");
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          check("wb_mask", 32'(o_reg_ie), 32'(e.mask));
          check("wb_data", 32'(o_reg_data), 32'(e.data));
          check("wb_cycle", cyc, e.is_mem ? ack_cyc + 1 : e.cyc + 1);
        end
      end
      if (o_mem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          fail_now("bus_unexpected_req");
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("bus_addr", 32'(o_mem_addr), 32'(b.addr));
          check("bus_we", 32'(o_mem_we), 32'(b.we));
          check("bus_data", 32'(o_mem_data), 32'(b.data));
        end
        cap_we   = o_mem_we;
        cap_addr = o_mem_addr;
        cap_data = o_mem_data;
      end else if (o_mem_req && prev_req) begin
        check("bus_stable_addr", 32'(o_mem_addr), 32'(cap_addr));
        check("bus_stable_we", 32'(o_mem_we), 32'(cap_we));
        check("bus_stable_data", 32'(o_mem_data), 32'(cap_data));
      end else if (!o_mem_req) begin
        check("bus_we_idle", 32'(o_mem_we), 32'd0);
      end
    end
    prev_req = o_mem_req;
  end

  // bus slave: random wait states, plus occasional stray acks while idle
  task automatic slave_step();
    if (i_mem_ack) begin
      i_mem_ack = 1'b0;
      if (ack_real) begin
        ack_real = 1'b0;
        pending  = 1'b0;
      end
    end else if (o_mem_req) begin
      if (wait_cnt == 0) begin
        i_mem_ack = 1'b1;
        ack_real  = 1'b1;
        ack_cyc   = cyc;
        if (o_mem_we) begin
          slave_mem[o_mem_addr] = o_mem_data;
          i_mem_data = RW'($urandom);
        end else begin
          i_mem_data = slave_read(o_mem_addr);
        end
      end else begin
        wait_cnt--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      i_mem_ack  = 1'b1;
      i_mem_data = RW'($urandom);
    end
  endtask

  // driver: offers the next instruction whenever the stage reports idle
  task automatic drive_step();
    instr_t in;
    i_submit = 1'b0;
    #1;
    check("ready_idle", 32'(o_ready), 32'(!pending));
    if (pending) begin
      pend_cyc++;
      if (pend_cyc > 40) begin
        fail_now("ack_timeout");
        pending = 1'b0;
      end
      return;
    end
    if (instr_q.size() == 0) return;
    in = instr_q.pop_front();
    i_submit     = 1'b1;
    i_mem_access = in.mem;
    i_mem_we     = in.we;
    i_addr       = in.addr;
    i_data       = in.data;
    i_reg_ie     = in.mask;
    #1;
    check("ready_submit", 32'(o_ready), 32'(!in.mem));
    if (in.mem) begin
      bus_q.push_back('{we: in.we, addr: in.addr, data: in.data});
      if (in.we) begin
        ref_mem[in.addr] = in.data;
      end else if (in.mask != '0) begin
        exp_q.push_back('{mask: in.mask, data: ref_read(in.addr), is_mem: 1'b1, cyc: 0});
      end
      pending  = 1'b1;
      wait_cnt = in.wait_cycles;
      pend_cyc = 0;
    end else if (in.mask != '0) begin
      exp_q.push_back('{mask: in.mask, data: in.data, is_mem: 1'b0, cyc: cyc});
    end
  endtask

  function automatic instr_t mk(input logic mem, input logic we, input logic [RW-1:0] addr,
                                input logic [RW-1:0] data, input logic [REGNO-1:0] mask,
                                input int w);
    instr_t t;
    t.mem = mem; t.we = we; t.addr = addr; t.data = data; t.mask = mask; t.wait_cycles = w;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    int r;
    r = $urandom_range(0, 8);
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'hFFF8 + RW'($urandom_range(0, 11)), RW'($urandom),
              (r == 8) ? '0 : REGNO'(1) << r, $urandom_range(0, 3));
  endfunction

  initial begin
    // reset and reset-state checks
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_we", 32'(o_mem_we), 32'd0);
    check("rst_addr", 32'(o_mem_addr), 32'd0);
    check("rst_data", 32'(o_mem_data), 32'd0);
    check("rst_reg_ie", 32'(o_reg_ie), 32'd0);
    check("rst_reg_data", 32'(o_reg_data), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    monitor_on = 1'b1;

    // directed: ALU passthrough, zero-wait load, three-wait load, store,
    // then ALU -> load -> ALU back-to-back
    instr_q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h1234, 8'h04, 0));
    instr_q.push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0000, 8'h02, 0));
    instr_q.push_back(mk(1'b1, 1'b0, 16'h0042, 16'h0000, 8'h10, 3));
    instr_q.push_back(mk(1'b1, 1'b1, 16'h0100, 16'hA5A5, 8'h00, 2));
    instr_q.push_back(mk(1'b1, 1'b0, 16'h0100, 16'h0000, 8'h01, 1));
    instr_q.push_back(mk(1'b1, 1'b0, 16'h0200, 16'h0000, 8'h00, 0));
    instr_q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h1111, 8'h08, 0));
    instr_q.push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0000, 8'h20, 0));
    instr_q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h2222, 8'h40, 0));
    instr_q.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h3333, 8'h80, 0));
    for (int i = 0; i < 300; i++) instr_q.push_back(rand_instr());

    for (int n = 0; n < 5000 && (instr_q.size() != 0 || pending); n++) begin
      @(negedge i_clk);
      slave_step();
      drive_step();
    end
    repeat (4) begin
      @(negedge i_clk);
      slave_step();
      i_submit = 1'b0;
    end
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("drain_wb_queue", exp_q.size(), 0);
    check("drain_bus_queue", bus_q.size(), 0);

    // reset in the middle of a bus wait; a late ack afterwards must be ignored
    i_submit = 1'b1; i_mem_access = 1'b1; i_mem_we = 1'b0;
    i_addr = 16'h0300; i_data = 16'h0000; i_reg_ie = 8'h01;
    bus_q.push_back('{we: 1'b0, addr: 16'h0300, data: 16'h0000});
    @(negedge i_clk);
    i_submit = 1'b0;
    #1;
    check("wait_req_high", 32'(o_mem_req), 32'd1);
    check("wait_ready_low", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("midrst_req", 32'(o_mem_req), 32'd0);
    check("midrst_reg_ie", 32'(o_reg_ie), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    i_mem_ack = 1'b1;
    i_mem_data = 16'hDEAD;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    #1;
    check("late_ack_reg_ie", 32'(o_reg_ie), 32'd0);
    check("late_ack_req", 32'(o_mem_req), 32'd0);
    check("late_ack_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    check("final_wb_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes execute's registered result (address, data, register write-enable mask, memory-access flags) under a submit/ready handshake.
- Non-memory instructions: forwards the ALU result to register-file writeback.
- Memory instructions: runs one req/ack transaction on the data-memory bus, then writes back the load data (loads) or nothing (stores).
- Output ports i_reg_ie/i_reg_data of execute are driven from this block's o_reg_ie/o_reg_data.

Parameters:
- RW, 16, data/address word width (equals `RW in config.v).
- REGNO, 8, number of registers; width of the one-hot write-enable mask (equals `REGNO).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_ready  out  1  stage can accept i_submit this cycle.
- i_submit  in  1  execute result valid this cycle.
- i_data  in  RW  ALU result (non-mem) or store data (mem).
- i_addr  in  RW  memory address.
- i_reg_ie  in  REGNO  one-hot destination mask; 0 = no writeback.
- i_mem_access  in  1  instruction accesses memory.
- i_mem_we  in  1  1 = store, 0 = load (valid only with i_mem_access).
- o_mem_req  out  1  bus request, held high until ack.
- o_mem_we  out  1  bus write strobe.
- o_mem_addr  out  RW  bus address.
- o_mem_data  out  RW  bus write data.
- i_mem_ack  in  1  bus completion; sampled only while o_mem_req=1.
- i_mem_data  in  RW  load data, valid with i_mem_ack.
- o_reg_ie  out  REGNO  writeback enable; one-cycle pulse.
- o_reg_data  out  RW  writeback data, valid when o_reg_ie != 0.

Behaviour:
- States: IDLE, MEM_WAIT (encoding localparam; 1 bit sufficient).
- Reset:
  - state=IDLE; o_mem_req=0; o_mem_we=0; o_reg_ie=0.
  - o_mem_addr, o_mem_data, o_reg_data reset to 0.
- Ready: o_ready = (state==IDLE) & ~(i_submit & i_mem_access). Combinational.
  - Drops in the same cycle a memory instruction arrives, so execute cannot issue a second instruction into the busy stage.
- o_reg_ie default: 0 every cycle unless a writeback is registered at the preceding edge. Never held for two cycles by one instruction.
- IDLE, i_submit=1, i_mem_access=0:
  - Next edge: o_reg_ie<=i_reg_ie, o_reg_data<=i_data. Latency 1 cycle.
  - Stay IDLE.
- IDLE, i_submit=1, i_mem_access=1:
  - Next edge: o_mem_req<=1, o_mem_we<=i_mem_we, o_mem_addr<=i_addr, o_mem_data<=i_data.
  - Latch i_reg_ie internally; go to MEM_WAIT.
- MEM_WAIT, i_mem_ack=0: hold all bus outputs stable; o_reg_ie=0.
- MEM_WAIT, i_mem_ack=1, next edge:
  - o_mem_req<=0, o_mem_we<=0, state<=IDLE.
  - Load: o_reg_ie<=latched mask, o_reg_data<=i_mem_data.
  - Store: o_reg_ie<=0.
- Minimum memory latency: submit cycle S, req high in S+1, ack in S+1, writeback pulse in S+2. o_ready is high again in S+2.
- i_mem_ack while o_mem_req=0: ignored.
- i_submit while in MEM_WAIT: protocol violation. Ignored; covered by a simulation assertion.
- Load with i_reg_ie=0: bus transaction still runs; no writeback.
- Reset during MEM_WAIT: request abandoned; req drops next edge. The bus slave must tolerate an abandoned request.
- Addresses wrap naturally at RW bits; no alignment checks.

Decomposition:
- RW and REGNO come from the shared config.v defines.
- State localparams stay local to the module.
- No sub-module: single FSM plus output registers.
- The bus port group matches the fetch-side memory port, so a later shared arbiter can merge the two.

Test Plan:
- ALU passthrough: submit i_data=0x1234, i_reg_ie=8'b0000_0100, mem_access=0 -> next cycle o_reg_ie=0x04, o_reg_data=0x1234; following cycle o_reg_ie=0; o_ready never drops.
- Zero-wait load: submit addr=0x0040, we=0, reg_ie=0x02; ack in the first req cycle with i_mem_data=0xBEEF -> writeback 0x02/0xBEEF two cycles after submit; o_ready low in the submit and req cycles only.
- Three-wait load: ack after 3 req cycles -> req, addr and we stable throughout; writeback one cycle after ack; no o_reg_ie pulse before that.
- Store: submit addr=0x0100, data=0xA5A5, we=1, reg_ie=0 -> o_mem_we=1, o_mem_data=0xA5A5 while req high; no writeback pulse after ack.
- Back-to-back: ALU op immediately followed by a load, then an ALU op held off by o_ready=0 -> writebacks occur in program order; no instruction lost or duplicated.
- Reset mid-wait: assert i_rst during MEM_WAIT -> next cycle req=0, o_reg_ie=0, o_ready=1; a late ack is ignored.
